// File: rtl/wall_column_buffer.sv
// Double-buffered per-column wall heights with a 2-stage pixel classification pipeline.
// Optional feature macro: WALL_SHADE_EN (store the wall face bit per column, drive pixel_shade).
module wall_column_buffer #(
  parameter int NUM_COLS = 640,
  parameter int SCREEN_H = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       height_valid,
  input  logic [9:0] wall_height,
  input  logic       side,
  input  logic       vsync_pulse,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       pixel_active,
  output logic       write_new_frame,
  output logic       pixel_valid,
  output logic       pixel_is_wall,
  output logic       pixel_is_ceiling,
  output logic       pixel_shade,
  output logic       overflow
);

  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
`ifdef WALL_SHADE_EN
  localparam int ENT_W = 11;
`else
  localparam int ENT_W = 10;
`endif
  localparam logic [10:0]      SCREEN_H_L = 11'(SCREEN_H);
  localparam logic [10:0]      NUM_COLS_L = 11'(NUM_COLS);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLS - 1);
  localparam logic [COL_W-1:0] COL_ONE    = COL_W'(1);

  typedef enum logic {ST_FILL = 1'b0, ST_FULL = 1'b1} state_t;

  function automatic logic [9:0] clamp_height(input logic [9:0] h);
    if ({1'b0, h} > SCREEN_H_L) begin
      clamp_height = SCREEN_H_L[9:0];
    end else begin
      clamp_height = h;
    end
  endfunction

  state_t              state_r, state_next_s;
  logic [COL_W-1:0]    wr_ptr_r, wr_ptr_next_s;
  logic                disp_bank_r, disp_valid_r, overflow_r, wnf_r;
  logic                wr_en_s, swap_s, ovf_set_s;
  logic [ENT_W-1:0]    wr_data_s;
  logic [ENT_W-1:0]    mem_r [0:1][0:NUM_COLS-1];

  logic                in_range_s;
  logic [COL_W-1:0]    rd_col_s;
  logic [ENT_W-1:0]    s1_entry_r;
  logic [9:0]          s1_y_r;
  logic                s1_act_r, s1_en_r;
  logic [9:0]          h_s;
  logic [10:0]         top_s, bot_s, y_s;
  logic                wall_s, ceil_s, shade_s;
  logic                s2_valid_r, s2_wall_r, s2_ceil_r, s2_shade_r;

`ifdef WALL_SHADE_EN
  assign wr_data_s = {clamp_height(wall_height), side};
`else
  logic unused_side_s;
  assign unused_side_s = side;
  assign wr_data_s     = clamp_height(wall_height);
`endif

  // Fill/full sequencing: writes only while filling, swap only once a frame is complete.
  always_comb begin
    state_next_s  = state_r;
    wr_ptr_next_s = wr_ptr_r;
    wr_en_s       = 1'b0;
    swap_s        = 1'b0;
    ovf_set_s     = 1'b0;
    case (state_r)
      ST_FILL: begin
        if (height_valid) begin
          wr_en_s = 1'b1;
          if (wr_ptr_r == LAST_COL) begin
            wr_ptr_next_s = {COL_W{1'b0}};
            state_next_s  = ST_FULL;
          end else begin
            wr_ptr_next_s = wr_ptr_r + COL_ONE;
          end
        end else begin
          wr_ptr_next_s = wr_ptr_r;
        end
      end
      ST_FULL: begin
        ovf_set_s = height_valid;
        if (vsync_pulse) begin
          swap_s       = 1'b1;
          state_next_s = ST_FILL;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: state_next_s = ST_FILL;
    endcase
  end

  // Control state, bank selection and sticky status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_FILL;
      wr_ptr_r     <= {COL_W{1'b0}};
      disp_bank_r  <= 1'b0;
      disp_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      wnf_r        <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      wr_ptr_r   <= wr_ptr_next_s;
      overflow_r <= overflow_r | ovf_set_s;
      wnf_r      <= (state_next_s == ST_FILL);
      if (swap_s) begin
        disp_bank_r  <= ~disp_bank_r;
        disp_valid_r <= 1'b1;
      end
    end
  end

  // Column store; contents are left unreset because disp_valid masks stale data.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[~disp_bank_r][wr_ptr_r] <= wr_data_s;
    end
  end

  assign in_range_s = ({1'b0, pixel_x} < NUM_COLS_L);
  assign rd_col_s   = in_range_s ? pixel_x[COL_W-1:0] : {COL_W{1'b0}};

  // Read stage 1: fetch the display entry and register the pixel position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_entry_r <= {ENT_W{1'b0}};
      s1_y_r     <= 10'd0;
      s1_act_r   <= 1'b0;
      s1_en_r    <= 1'b0;
    end else begin
      s1_entry_r <= mem_r[disp_bank_r][rd_col_s];
      s1_y_r     <= pixel_y;
      s1_act_r   <= pixel_active;
      s1_en_r    <= pixel_active & in_range_s & disp_valid_r;
    end
  end

  // The wall is centred vertically: top = (SCREEN_H - h) / 2, bottom = top + h.
  assign h_s    = s1_entry_r[ENT_W-1 -: 10];
  assign top_s  = (SCREEN_H_L - {1'b0, h_s}) >> 1'b1;
  assign bot_s  = top_s + {1'b0, h_s};
  assign y_s    = {1'b0, s1_y_r};
  assign wall_s = s1_en_r & (y_s >= top_s) & (y_s < bot_s);
  assign ceil_s = s1_en_r & (y_s < top_s);
`ifdef WALL_SHADE_EN
  assign shade_s = wall_s & s1_entry_r[0];
`else
  assign shade_s = 1'b0;
`endif

  // Read stage 2: registered classification outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_wall_r  <= 1'b0;
      s2_ceil_r  <= 1'b0;
      s2_shade_r <= 1'b0;
    end else begin
      s2_valid_r <= s1_act_r;
      s2_wall_r  <= wall_s;
      s2_ceil_r  <= ceil_s;
      s2_shade_r <= shade_s;
    end
  end

  assign write_new_frame  = wnf_r;
  assign overflow         = overflow_r;
  assign pixel_valid      = s2_valid_r;
  assign pixel_is_wall    = s2_wall_r;
  assign pixel_is_ceiling = s2_ceil_r;
  assign pixel_shade      = s2_shade_r;

endmodule

// File: tb/tb_wall_column_buffer.sv
// Scoreboard bench for wall_column_buffer: random heights and pixels against a frame-level model.
module tb_wall_column_buffer;
  localparam int NUM_COLS = 640;
  localparam int SCREEN_H = 480;
`ifdef WALL_SHADE_EN
  localparam bit SHADE_EN = 1'b1;
`else
  localparam bit SHADE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, height_valid, side, vsync_pulse, pixel_active;
  logic [9:0] wall_height, pixel_x, pixel_y;
  logic write_new_frame, pixel_valid, pixel_is_wall, pixel_is_ceiling, pixel_shade, overflow;

  wall_column_buffer #(.NUM_COLS(NUM_COLS), .SCREEN_H(SCREEN_H)) dut (
    .clk(clk), .rst_n(rst_n), .height_valid(height_valid), .wall_height(wall_height),
    .side(side), .vsync_pulse(vsync_pulse), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_active(pixel_active), .write_new_frame(write_new_frame), .pixel_valid(pixel_valid),
    .pixel_is_wall(pixel_is_wall), .pixel_is_ceiling(pixel_is_ceiling),
    .pixel_shade(pixel_shade), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int issue; logic [2:0] e;} pix_t;
  pix_t exp_q[$];
  int checks = 0, failures = 0, cyc = 0;
  bit mon_en = 1'b0;

  // Reference model: frame being written, frame on display, flags.
  int m_wh[NUM_COLS];
  bit m_ws[NUM_COLS];
  int m_dh[NUM_COLS];
  bit m_ds[NUM_COLS];
  int m_cnt = 0;
  bit m_full = 1'b0, m_dvalid = 1'b0, m_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_pix(input int x, input int y);
    int h, top, bot;
    bit w, c, s;
    if (!m_dvalid || x >= NUM_COLS) return 3'b000;
    h   = m_dh[x];
    top = (SCREEN_H - h) / 2;
    bot = top + h;
    w   = (y >= top) && (y < bot);
    c   = (y < top);
    s   = SHADE_EN && w && m_ds[x];
    return {w, c, s};
  endfunction

  // One clock of stimulus; model state is advanced as the DUT should at this edge.
  task automatic step(input bit hv, input int h, input bit sd, input bit vs,
                      input int px, input int py, input bit pa);
    bit was_full;
    pix_t p;
    height_valid = hv; wall_height = 10'(h); side = sd; vsync_pulse = vs;
    pixel_x = 10'(px); pixel_y = 10'(py); pixel_active = pa;
    if (pa) begin
      p.x = px; p.y = py; p.issue = cyc; p.e = exp_pix(px, py);
      exp_q.push_back(p);
    end
    was_full = m_full;
    if (hv) begin
      if (!was_full) begin
        m_wh[m_cnt] = (h > SCREEN_H) ? SCREEN_H : h;
        m_ws[m_cnt] = sd;
        m_cnt++;
        if (m_cnt == NUM_COLS) begin
          m_cnt  = 0;
          m_full = 1'b1;
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (vs && was_full) begin
      m_dh = m_wh; m_ds = m_ws; m_dvalid = 1'b1; m_full = 1'b0;
    end
    @(posedge clk); #1;
    height_valid = 1'b0; vsync_pulse = 1'b0; pixel_active = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic scan(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 0, 1'b0, 1'b0, int'($urandom_range(0, 719)),
           int'($urandom_range(0, SCREEN_H - 1)), ($urandom_range(0, 3) != 0));
  endtask

  // Probe the lines around each span edge of random columns.
  task automatic scan_edges(input int n);
    for (int i = 0; i < n; i++) begin
      int x, top, bot;
      int ys[4];
      x = int'($urandom_range(0, NUM_COLS - 1));
      top = (SCREEN_H - m_dh[x]) / 2;
      bot = top + m_dh[x];
      ys[0] = top - 1; ys[1] = top; ys[2] = bot - 1; ys[3] = bot;
      for (int k = 0; k < 4; k++)
        if (ys[k] >= 0 && ys[k] < SCREEN_H) step(1'b0, 0, 1'b0, 1'b0, x, ys[k], 1'b1);
    end
  endtask

  task automatic fill_frame(input int mode, input bit coincide);
    for (int c = 0; c < NUM_COLS; c++) begin
      int h;
      bit sd;
      sd = 1'($urandom_range(0, 1));
      case (mode)
        0: begin
          h = (c == 0) ? 900 : 100;
          if (c == 2 || c == 4) sd = 1'b0;
        end
        1: begin
          case ($urandom_range(0, 3))
            0: h = 0;
            1: h = SCREEN_H;
            2: h = int'($urandom_range(SCREEN_H + 1, 1023));
            default: h = int'($urandom_range(1, SCREEN_H - 1));
          endcase
        end
        default: h = int'($urandom_range(0, 1023));
      endcase
      if (c == 3) sd = 1'b1;
      step(1'b1, h, sd, coincide && (c == NUM_COLS - 1), 0, 0, 1'b0);
    end
  endtask

  task automatic reset_pulse();
    idle(3);
    rst_n = 1'b0;
    m_cnt = 0; m_full = 1'b0; m_dvalid = 1'b0; m_ovf = 1'b0;
    @(posedge clk); #1;
    check("overflow_in_reset", int'(overflow), 0);
    check("pixel_valid_in_reset", int'(pixel_valid), 0);
    rst_n = 1'b1;
    idle(2);
    check("wnf_after_reset", int'(write_new_frame), 1);
  endtask

  // Monitor: pops one expectation per presented pixel, checks values and latency.
  always @(negedge clk) begin : monitor
    pix_t p;
    if (mon_en) begin
      if (pixel_valid) begin
        if (exp_q.size() == 0) begin
          check("pixel_valid_unexpected", int'(pixel_valid), 0);
        end else begin
          p = exp_q.pop_front();
          check($sformatf("pix(%0d,%0d){wall,ceil,shade}", p.x, p.y),
                int'({pixel_is_wall, pixel_is_ceiling, pixel_shade}), int'(p.e));
          check("latency", cyc - p.issue, 2);
        end
      end else begin
        check("idle_outputs", int'({pixel_is_wall, pixel_is_ceiling, pixel_shade}), 0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; height_valid = 1'b0; wall_height = 10'd0; side = 1'b0;
    vsync_pulse = 1'b0; pixel_x = 10'd0; pixel_y = 10'd0; pixel_active = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel_valid", int'(pixel_valid), 0);
    check("rst_wall", int'(pixel_is_wall), 0);
    check("rst_ceiling", int'(pixel_is_ceiling), 0);
    check("rst_shade", int'(pixel_shade), 0);
    check("rst_overflow", int'(overflow), 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    idle(2);
    check("wnf_after_reset", int'(write_new_frame), 1);

    // No frame displayed yet; a vsync while filling must be ignored.
    scan(40);
    step(1'b0, 0, 1'b0, 1'b1, 0, 0, 1'b0);
    check("wnf_vsync_in_fill", int'(write_new_frame), int'(!m_full));
    scan(20);

    // Frame A: all 100 except a clamped 900 at column 0.
    fill_frame(0, 1'b0);
    check("wnf_full_a", int'(write_new_frame), int'(!m_full));
    step(1'b0, 0, 1'b0, 1'b1, 0, 0, 1'b0);
    check("wnf_swap_a", int'(write_new_frame), int'(!m_full));
    step(1'b0, 0, 1'b0, 1'b0, 5, 190, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 5, 189, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 5, 290, 1'b1);
    for (int y = 0; y < SCREEN_H; y += 53) step(1'b0, 0, 1'b0, 1'b0, 0, y, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 0, SCREEN_H - 1, 1'b1);
    for (int x = 2; x <= 4; x++) step(1'b0, 0, 1'b0, 1'b0, x, 200, 1'b1);
    scan_edges(15);
    scan(80);

    // Frame B: boundary heights, then one height too many.
    fill_frame(1, 1'b0);
    step(1'b1, 123, 1'b1, 1'b0, 0, 0, 1'b0);
    check("overflow_set", int'(overflow), int'(m_ovf));
    check("wnf_full_b", int'(write_new_frame), int'(!m_full));
    step(1'b0, 0, 1'b0, 1'b1, 0, 0, 1'b0);
    check("wnf_swap_b", int'(write_new_frame), int'(!m_full));
    check("overflow_sticky", int'(overflow), int'(m_ovf));
    scan_edges(20);
    scan(80);

    // Frame C: last write coincides with vsync, so frame B stays on display.
    fill_frame(2, 1'b1);
    check("wnf_coincide", int'(write_new_frame), int'(!m_full));
    scan_edges(10);
    scan(40);
    step(1'b0, 0, 1'b0, 1'b1, 0, 0, 1'b0);
    check("wnf_swap_c", int'(write_new_frame), int'(!m_full));
    scan_edges(15);
    scan(60);

    // Reset mid-fill discards the partial frame; the next one starts at column 0.
    for (int c = 0; c < 100; c++) step(1'b1, int'($urandom_range(0, 1023)), 1'b0, 1'b0, 0, 0, 1'b0);
    reset_pulse();
    scan(30);
    fill_frame(1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 0, 0, 1'b0);
    check("wnf_swap_d", int'(write_new_frame), int'(!m_full));
    check("overflow_after_reset", int'(overflow), int'(m_ovf));
    scan_edges(15);
    scan(60);

    idle(4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wall_column_buffer.md
WALL_COLUMN_BUFFER -- requirements
Module: wall_column_buffer

Interface
REQ-001 SHALL have parameter NUM_COLS, default 640: screen columns, one ray per column.
REQ-002 SHALL have parameter SCREEN_H, default 480: visible lines; wall heights are clamped to this value.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port height_valid, input, 1: one-cycle strobe marking a valid wall_height (from the height stage's found flag).
REQ-006 SHALL have port wall_height, input, 10: column wall height in pixels.
REQ-007 SHALL have port side, input, 1: wall face hit (0 = x side, 1 = y side), sampled with height_valid.
REQ-008 SHALL have port vsync_pulse, input, 1: one-cycle frame-boundary strobe from the video timing.
REQ-009 SHALL have port pixel_x, input, 10: current pixel column.
REQ-010 SHALL have port pixel_y, input, 10: current pixel line.
REQ-011 SHALL have port pixel_active, input, 1: pixel_x and pixel_y are in the visible area.
REQ-012 SHALL have port write_new_frame, output, 1: high while the write bank accepts heights.
REQ-013 SHALL have port pixel_valid, output, 1: pixel_active delayed 2 cycles.
REQ-014 SHALL have port pixel_is_wall, output, 1: pixel lies inside the wall span.
REQ-015 SHALL have port pixel_is_ceiling, output, 1: pixel lies above the wall span.
REQ-016 SHALL have port pixel_shade, output, 1: side bit of the wall pixel.
REQ-017 SHALL have port overflow, output, 1: sticky flag for a height dropped while the write bank was full.

Function
REQ-018 SHALL hold two banks of NUM_COLS entries: a write bank and a display bank.
REQ-019 SHALL write {clamped height, side} at wr_ptr of the write bank on each height_valid in state FILL, then increment wr_ptr.
REQ-020 SHALL clamp the stored height to min(wall_height, SCREEN_H).
REQ-021 SHALL move FILL->FULL when wr_ptr = NUM_COLS-1 is written; wr_ptr wraps to 0.
REQ-022 SHALL, on vsync_pulse in FULL: swap the banks, set disp_valid = 1, enter FILL; write_new_frame = 1 from the next cycle.
REQ-023 SHALL ignore vsync_pulse in FILL: no swap, wr_ptr unchanged.
REQ-024 SHALL drive write_new_frame = 1 in FILL and 0 in FULL.
REQ-025 SHALL, on height_valid in FULL, discard the data and set overflow; overflow clears only on reset.
REQ-026 SHALL, when the last-column write and vsync_pulse occur in the same cycle: commit the write, enter FULL, no swap; the swap waits for the next vsync_pulse.
REQ-027 SHALL use a 2-stage read pipeline: stage 1 registers the display-bank entry at pixel_x plus pixel_y and pixel_active; stage 2 registers the comparison outputs.
REQ-028 SHALL compute top = (SCREEN_H - h) >> 1 and bottom = top + h, in 11-bit unsigned arithmetic.
REQ-029 SHALL set pixel_is_wall = (top <= y < bottom) and pixel_is_ceiling = (y < top).
REQ-030 SHALL force pixel_is_wall, pixel_is_ceiling and pixel_shade to 0 when pixel_active = 0, pixel_x >= NUM_COLS, or disp_valid = 0.
REQ-031 SHALL produce no wall pixels for h = 0; for h = SCREEN_H every visible line is wall.

Reset
REQ-032 SHALL, while rst_n = 0, asynchronously set state = FILL, wr_ptr = 0, display bank = bank 0, disp_valid = 0, overflow = 0, and all pipeline registers and outputs = 0.
REQ-033 SHALL leave memory contents unreset; disp_valid masks stale data.
REQ-034 SHALL, on reset asserted mid-fill, discard the partial frame; the next frame restarts at column 0.
REQ-035 SHALL drive write_new_frame = 1 from the first cycle after rst_n deasserts.

Configuration
REQ-036 SHALL, with WALL_SHADE_EN defined, store the side bit per entry (11-bit entries) and drive pixel_shade = stored side on wall pixels.
REQ-037 SHALL, without WALL_SHADE_EN, use 10-bit entries, ignore side, and tie pixel_shade to 0.

Verification
REQ-038 Reset then pixel scan with no vsync -> pixel_is_wall = 0 everywhere; write_new_frame = 1.
REQ-039 640 heights of 100, then vsync, then pixel (5, 190) -> pixel_is_wall = 1, 2 cycles later; (5, 189) -> pixel_is_ceiling = 1; (5, 290) -> floor (wall = 0, ceiling = 0).
REQ-040 Height 900 at column 0 -> clamped to 480; every line at x = 0 is wall.
REQ-041 641st height_valid before vsync -> dropped, overflow = 1, write_new_frame = 0; vsync -> swap, write_new_frame = 1.
REQ-042 Last-column write coincident with vsync -> no swap that frame; swap on the following vsync.
REQ-043 With WALL_SHADE_EN, side = 1 on column 3 -> pixel_shade = 1 on column 3 wall pixels only.
